sipo_rx: RTL and testbench

//   Serial-in/parallel-out word receiver: the receive end of the LSB-first

---
 rtl/sipo_rx.sv | 169 ++++++++++++++++
 tb/tb_sipo_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// LSB-first serial-in/parallel-out word receiver with a valid/ready output buffer,
// overrun and abort pulses. Optional even-parity bit per frame under SIPO_PARITY_EN.
module sipo_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_en,
  input  logic             s_start,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  input  logic             d_ready,
  output logic             busy,
  output logic             overrun,
  output logic             abort
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SIPO_PARITY_EN
    ,
    PAR   = 2'd2
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_shift;
  logic             w_complete;
  logic             w_abort;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_dout;
  logic             r_dvalid;
  logic             r_overrun;
  logic             r_abort;
`ifdef SIPO_PARITY_EN
  logic             w_perr;
  logic             r_perr;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_shift      = 1'b0;
    w_complete   = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_en && s_start) begin
          w_shift      = 1'b1;
          w_cnt_next   = CNT_ONE;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (s_en) begin
          w_shift = 1'b1;
          if (s_start) begin
            // A start marker mid-frame drops the partial word and opens a new one.
            w_abort    = 1'b1;
            w_cnt_next = CNT_ONE;
          end else if (r_cnt == CNT_LAST) begin
            w_cnt_next = '0;
`ifdef SIPO_PARITY_EN
            w_next_state = PAR;
`else
            w_complete   = 1'b1;
            w_next_state = IDLE;
`endif
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
      end
`ifdef SIPO_PARITY_EN
      PAR: begin
        if (s_en) begin
          if (s_start) begin
            w_abort      = 1'b1;
            w_shift      = 1'b1;
            w_cnt_next   = CNT_ONE;
            w_next_state = SHIFT;
          end else begin
            w_complete   = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  assign w_sr_next = w_shift ? {s_in, r_sr[WIDTH-1:1]} : r_sr;

`ifdef SIPO_PARITY_EN
  // The parity bit is never shifted in; the data word is already in place.
  assign w_word = r_sr;
  assign w_perr = ^{r_sr, s_in};
`else
  assign w_word = w_sr_next;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_sr    <= w_sr_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout    <= '0;
      r_dvalid  <= 1'b0;
      r_overrun <= 1'b0;
      r_abort   <= 1'b0;
`ifdef SIPO_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      r_abort   <= w_abort;
      r_overrun <= w_complete && r_dvalid && !d_ready;
      if (w_complete) begin
        if (!r_dvalid || d_ready) begin
          r_dout   <= w_word;
          r_dvalid <= 1'b1;
`ifdef SIPO_PARITY_EN
          r_perr   <= w_perr;
`endif
        end
      end else if (r_dvalid && d_ready) begin
        r_dvalid <= 1'b0;
      end
    end
  end

  assign d_out   = r_dout;
  assign d_valid = r_dvalid;
  assign overrun = r_overrun;
  assign abort   = r_abort;
  assign busy    = (r_state != IDLE);
`ifdef SIPO_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (WIDTH=4): framing, gaps, overrun, abort, async reset,
// and the parity bit when SIPO_PARITY_EN is defined.
module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_in, s_en, s_start, d_ready;
  logic [3:0] d_out;
  logic       d_valid, busy, overrun, abort;
`ifdef SIPO_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sipo_rx #(.WIDTH(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_in      (s_in),
    .s_en      (s_en),
    .s_start   (s_start),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .busy      (busy),
    .overrun   (overrun),
    .abort     (abort)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, return 1 time unit after the rising edge.
  task automatic cyc(input logic en, input logic din, input logic st, input logic rdy);
    @(negedge clk);
    s_en    = en;
    s_in    = din;
    s_start = st;
    d_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Full frame, LSB first; rdy_last is d_ready on the completing bit.
  task automatic frame(input logic [3:0] w, input logic rdy_last);
    for (int i = 0; i < 4; i++) begin
`ifdef SIPO_PARITY_EN
      cyc(1'b1, w[i], i == 0, 1'b0);
`else
      cyc(1'b1, w[i], i == 0, (i == 3) ? rdy_last : 1'b0);
`endif
    end
`ifdef SIPO_PARITY_EN
    cyc(1'b1, ^w, 1'b0, rdy_last);
`endif
  endtask

  initial begin
    rst = 1'b0; s_in = 1'b0; s_en = 1'b0; s_start = 1'b0; d_ready = 1'b0;
    #2;
    check("rst_dout", d_out, 4'h0);
    check("rst_dvalid", d_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_abort", abort, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Bit without start in IDLE is ignored.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_ignore_busy", busy, 1'b0);

    // Basic frame 1,0,1,1 -> 4'b1101.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("f1_busy", busy, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("f1_valid_early", d_valid, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    check("f1_busy_par", busy, 1'b1);
    check("f1_valid_par", d_valid, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
`endif
    check("f1_dout", d_out, 4'hD);
    check("f1_valid", d_valid, 1'b1);
    check("f1_busy_end", busy, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("f1_consumed", d_valid, 1'b0);
    check("f1_dout_hold", d_out, 4'hD);

    // Bits 1,1,0,0 separated by s_en=0 gaps -> 4'b0011.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("gap_busy", busy, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("gap_valid_early", d_valid, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
`endif
    check("gap_dout", d_out, 4'h3);
    check("gap_valid", d_valid, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: A unconsumed, then B back-to-back.
    frame(4'hA, 1'b0);
    check("ovr_a_dout", d_out, 4'hA);
    check("ovr_a_flag", overrun, 1'b0);
    frame(4'h5, 1'b0);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_dout_kept", d_out, 4'hA);
    check("ovr_valid", d_valid, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse_end", overrun, 1'b0);
    frame(4'h5, 1'b1);
    check("ovr_rdy_dout", d_out, 4'h5);
    check("ovr_rdy_valid", d_valid, 1'b1);
    check("ovr_rdy_flag", overrun, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_consumed", d_valid, 1'b0);

    // Abort after two bits, then new frame 0,1,1,1 -> 4'b1110.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("abt_flag", abort, 1'b1);
    check("abt_busy", busy, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("abt_pulse_end", abort, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
`endif
    check("abt_dout", d_out, 4'hE);
    check("abt_valid", d_valid, 1'b1);
    check("abt_no_ovr", overrun, 1'b0);

    // Async reset mid-frame while a word is held.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("ar_busy_before", busy, 1'b1);
    @(negedge clk);
    s_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("ar_dout", d_out, 4'h0);
    check("ar_valid", d_valid, 1'b0);
    check("ar_busy", busy, 1'b0);
    #1 rst = 1'b1;
    frame(4'h5, 1'b0);
    check("ar_next_dout", d_out, 4'h5);
    check("ar_next_valid", d_valid, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
    // Data 1,0,1,1 (three ones): parity bit 1 is even -> no error; 0 -> error.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("par1_valid_early", d_valid, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("par1_valid", d_valid, 1'b1);
    check("par1_dout", d_out, 4'hD);
    check("par1_err", parity_err, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("par0_dout", d_out, 4'hD);
    check("par0_err", parity_err, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
